// File: rtl/cpu_io_nibble_bridge.sv
// CPU-to-fabric nibble bridge.
// A captured opcode and two 32-bit operands are streamed to the fabric as a
// sync/opcode header followed by eight nibble beats per lane. The bridge then
// collects four result bytes, or gives up after TIMEOUT_CYCLES and reports an
// error.
module cpu_io_nibble_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        UserCLK,
  input  logic        RST,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [3:0]  OPA_O,
  output logic [3:0]  OPB_O,
  input  logic [3:0]  RES0_I,
  input  logic [3:0]  RES1_I,
  input  logic [3:0]  RES2_I,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    SEND     = 3'd2,
    WAIT_RES = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [3:0]  SYNC_NIBBLE   = 4'b1010;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [2:0]  send_cnt_q, send_cnt_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  opb_q, opb_d;

  logic       beat_valid;
  logic       beat_err;
  logic [4:0] nib_idx;
  logic       unused_ctrl;

  assign beat_valid  = RES2_I[0];
  assign beat_err    = RES2_I[1];
  // Upper control bits carry no meaning for this bridge.
  assign unused_ctrl = ^RES2_I[3:2];

  // State, captured operands, counters and the registered lane outputs.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      send_cnt_q <= '0;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      send_cnt_q <= send_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      result_q   <= result_d;
      error_q    <= error_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
    end
  end

  // Next-state logic; lane values are computed for the state being entered.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    opcode_d   = opcode_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    send_cnt_d = send_cnt_q;
    beat_cnt_d = beat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    result_d   = result_q;
    error_d    = error_q;
    opa_d      = '0;
    opb_d      = '0;
    nib_idx    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          opcode_d = opcode;
          op_a_d   = op_a;
          op_b_d   = op_b;
          result_d = '0;
          error_d  = 1'b0;
          opa_d    = SYNC_NIBBLE;
          opb_d    = opcode;
          state_d  = HDR;
        end
      end

      HDR: begin
        send_cnt_d = '0;
        opa_d      = op_a_q[3:0];
        opb_d      = op_b_q[3:0];
        state_d    = SEND;
      end

      SEND: begin
        if (send_cnt_q == 3'd7) begin
          tmo_cnt_d  = '0;
          beat_cnt_d = '0;
          state_d    = WAIT_RES;
        end else begin
          send_cnt_d = send_cnt_q + 3'd1;
          nib_idx    = {send_cnt_d, 2'b00};
          opa_d      = op_a_q[nib_idx +: 4];
          opb_d      = op_b_q[nib_idx +: 4];
        end
      end

      WAIT_RES: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (beat_valid) begin
          result_d[{beat_cnt_q, 3'b000} +: 8] = {RES1_I, RES0_I};
          if (beat_err) error_d = 1'b1;
          beat_cnt_d = beat_cnt_q + 2'd1;
        end
        // A fourth beat landing on the timeout cycle still completes normally.
        if (beat_valid && beat_cnt_q == 2'd3) begin
          state_d = DONE;
        end else if (tmo_cnt_d == TIMEOUT_LIMIT) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign OPA_O  = opa_q;
  assign OPB_O  = opb_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_cpu_io_nibble_bridge.sv
// Directed bench for cpu_io_nibble_bridge. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point, well clear of it.
module tb_cpu_io_nibble_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  opa, opb;
  logic [3:0]  res0 = '0;
  logic [3:0]  res1 = '0;
  logic [3:0]  res2 = '0;
  logic        busy, done, error;
  logic [31:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cpu_io_nibble_bridge #(.TIMEOUT_CYCLES(20)) dut (
    .UserCLK (clk),
    .RST     (rst),
    .start   (start),
    .opcode  (opcode),
    .op_a    (op_a),
    .op_b    (op_b),
    .OPA_O   (opa),
    .OPB_O   (opb),
    .RES0_I  (res0),
    .RES1_I  (res1),
    .RES2_I  (res2),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge; returns observing the HDR cycle.
  task automatic issue_start(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    opcode = opc;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Start a transaction and return observing the first WAIT_RES cycle.
  task automatic go_to_wait(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    issue_start(opc, a, b);
    repeat (9) tick();
  endtask

  // One valid result beat for one cycle.
  task automatic drive_beat(input logic [7:0] data, input logic err);
    res0 = data[3:0];
    res1 = data[7:4];
    res2 = {2'b00, err, 1'b1};
    tick();
    res2 = '0;
  endtask

  task automatic test_reset;
    #2;
    total_cnt++; if (opa !== 4'h0) $display("FAIL reset_opa got %h exp 0", opa); else pass_cnt++;
    total_cnt++; if (opb !== 4'h0) $display("FAIL reset_opb got %h exp 0", opb); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 0", result); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL reset_error got %b exp 0", error); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [3:0] exp_a, exp_b;
    issue_start(4'd3, 32'h8765_4321, 32'h0FED_CBA9);
    total_cnt++; if (opa !== 4'hA) $display("FAIL basic_hdr_opa got %h exp a", opa); else pass_cnt++;
    total_cnt++; if (opb !== 4'h3) $display("FAIL basic_hdr_opb got %h exp 3", opb); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_hdr_busy got %b exp 1", busy); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_a = 4'(k + 1);
      exp_b = 4'((9 + k) % 16);
      total_cnt++; if (opa !== exp_a) $display("FAIL basic_send_opa beat %0d got %h exp %h", k, opa, exp_a); else pass_cnt++;
      total_cnt++; if (opb !== exp_b) $display("FAIL basic_send_opb beat %0d got %h exp %h", k, opb, exp_b); else pass_cnt++;
    end
    tick();
    total_cnt++; if (opa !== 4'h0 || opb !== 4'h0) $display("FAIL basic_wait_lanes got %h/%h exp 0/0", opa, opb); else pass_cnt++;
    drive_beat(8'h78, 1'b0);
    drive_beat(8'h56, 1'b0);
    drive_beat(8'h34, 1'b0);
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_cycle13 got %b exp 0", done); else pass_cnt++;
    drive_beat(8'h12, 1'b0);
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done_cycle14 got %b exp 1", done); else pass_cnt++;
    total_cnt++; if (result !== 32'h1234_5678) $display("FAIL basic_result got %h exp 12345678", result); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL basic_error got %b exp 0", error); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after_done got done=%b busy=%b exp 0/0", done, busy); else pass_cnt++;
    total_cnt++; if (result !== 32'h1234_5678) $display("FAIL basic_result_hold got %h exp 12345678", result); else pass_cnt++;
  endtask

  task automatic test_gapped;
    go_to_wait(4'd5, 32'h1111_1111, 32'h2222_2222);
    drive_beat(8'hAA, 1'b0);
    repeat (3) tick();
    drive_beat(8'hBB, 1'b0);
    repeat (3) tick();
    drive_beat(8'hCC, 1'b0);
    repeat (3) tick();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL gapped_before_last got done=%b busy=%b exp 0/1", done, busy); else pass_cnt++;
    drive_beat(8'hDD, 1'b0);
    total_cnt++; if (done !== 1'b1) $display("FAIL gapped_done got %b exp 1", done); else pass_cnt++;
    total_cnt++; if (result !== 32'hDDCC_BBAA) $display("FAIL gapped_result got %h exp ddccbbaa", result); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL gapped_error got %b exp 0", error); else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout;
    go_to_wait(4'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h22, 1'b0);
    repeat (17) tick();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_early got done=%b busy=%b exp 0/1", done, busy); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b1) $display("FAIL timeout_done got %b exp 1", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b1) $display("FAIL timeout_error got %b exp 1", error); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL timeout_result got %h exp 0", result); else pass_cnt++;
    tick();
  endtask

  task automatic test_beat_wins_tie;
    go_to_wait(4'd2, 32'h0, 32'h0);
    drive_beat(8'h01, 1'b0);
    drive_beat(8'h02, 1'b0);
    drive_beat(8'h03, 1'b0);
    repeat (16) tick();
    drive_beat(8'h04, 1'b0);
    total_cnt++; if (done !== 1'b1) $display("FAIL tie_done got %b exp 1", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL tie_error got %b exp 0", error); else pass_cnt++;
    total_cnt++; if (result !== 32'h0403_0201) $display("FAIL tie_result got %h exp 04030201", result); else pass_cnt++;
    tick();
  endtask

  task automatic test_fabric_error;
    go_to_wait(4'd1, 32'h0000_0001, 32'h0000_0002);
    drive_beat(8'h9A, 1'b0);
    drive_beat(8'hBC, 1'b0);
    drive_beat(8'hDE, 1'b1);
    drive_beat(8'hF0, 1'b0);
    total_cnt++; if (done !== 1'b1) $display("FAIL ferr_done got %b exp 1", done); else pass_cnt++;
    total_cnt++; if (error !== 1'b1) $display("FAIL ferr_error got %b exp 1", error); else pass_cnt++;
    total_cnt++; if (result !== 32'hF0DE_BC9A) $display("FAIL ferr_result got %h exp f0debc9a", result); else pass_cnt++;
    tick();
    total_cnt++; if (error !== 1'b1) $display("FAIL ferr_error_hold got %b exp 1", error); else pass_cnt++;
    issue_start(4'd8, 32'h5555_5555, 32'hAAAA_AAAA);
    total_cnt++; if (error !== 1'b0) $display("FAIL ferr_next_error_clear got %b exp 0", error); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL ferr_next_result_clear got %h exp 0", result); else pass_cnt++;
    repeat (9) tick();
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h22, 1'b0);
    drive_beat(8'h33, 1'b0);
    drive_beat(8'h44, 1'b0);
    total_cnt++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL ferr_next_done got done=%b error=%b exp 1/0", done, error); else pass_cnt++;
    tick();
  endtask

  task automatic test_ignored;
    logic [3:0] exp_a, exp_b;
    res0 = 4'hF; res1 = 4'hF; res2 = 4'b0001;
    repeat (2) tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_idle_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (result !== 32'h4433_2211) $display("FAIL ign_idle_result got %h exp 44332211", result); else pass_cnt++;
    res2 = '0;
    issue_start(4'd6, 32'h7654_3210, 32'hFEDC_BA98);
    start = 1'b1;
    res0 = 4'hE; res1 = 4'hE; res2 = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_a = 4'(k);
      exp_b = 4'(8 + k);
      total_cnt++; if (opa !== exp_a || opb !== exp_b) $display("FAIL ign_send beat %0d got %h/%h exp %h/%h", k, opa, opb, exp_a, exp_b); else pass_cnt++;
    end
    res2 = '0;
    tick();
    total_cnt++; if (result !== 32'h0 || error !== 1'b0 || busy !== 1'b1) $display("FAIL ign_wait_entry got result=%h error=%b busy=%b exp 0/0/1", result, error, busy); else pass_cnt++;
    drive_beat(8'h10, 1'b0);
    drive_beat(8'h32, 1'b0);
    drive_beat(8'h54, 1'b0);
    drive_beat(8'h76, 1'b0);
    start = 1'b0;
    total_cnt++; if (done !== 1'b1 || result !== 32'h7654_3210) $display("FAIL ign_done got done=%b result=%h exp 1/76543210", done, result); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_back_idle got busy=%b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    go_to_wait(4'd7, 32'h0, 32'h0);
    drive_beat(8'hA1, 1'b0);
    drive_beat(8'hA2, 1'b0);
    drive_beat(8'hA3, 1'b0);
    drive_beat(8'hA4, 1'b0);
    opcode = 4'd9; op_a = 32'hCAFE_0123; op_b = 32'h0BAD_4567;
    start = 1'b1;
    tick();
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle got busy=%b done=%b exp 0/0", busy, done); else pass_cnt++;
    total_cnt++; if (result !== 32'hA4A3_A2A1) $display("FAIL b2b_first_result got %h exp a4a3a2a1", result); else pass_cnt++;
    tick();
    start = 1'b0;
    total_cnt++; if (opa !== 4'hA || opb !== 4'h9) $display("FAIL b2b_hdr got %h/%h exp a/9", opa, opb); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL b2b_result_clear got %h exp 0", result); else pass_cnt++;
    tick();
    total_cnt++; if (opa !== 4'h3 || opb !== 4'h7) $display("FAIL b2b_send0 got %h/%h exp 3/7", opa, opb); else pass_cnt++;
    repeat (8) tick();
    drive_beat(8'h0F, 1'b0);
    drive_beat(8'h1E, 1'b0);
    drive_beat(8'h2D, 1'b0);
    drive_beat(8'h3C, 1'b0);
    total_cnt++; if (done !== 1'b1 || result !== 32'h3C2D_1E0F) $display("FAIL b2b_second got done=%b result=%h exp 1/3c2d1e0f", done, result); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_send;
    issue_start(4'd2, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (5) tick();
    total_cnt++; if (opa !== 4'h7 || opb !== 4'h8) $display("FAIL rst_mid_beat4 got %h/%h exp 7/8", opa, opb); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (opa !== 4'h0 || opb !== 4'h0) $display("FAIL rst_mid_lanes got %h/%h exp 0/0", opa, opb); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_status got busy=%b done=%b exp 0/0", busy, done); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (done !== 1'b0) $display("FAIL rst_mid_no_done got %b exp 0", done); else pass_cnt++;
    end
    rst = 1'b0;
    tick();
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_release got done=%b busy=%b exp 0/0", done, busy); else pass_cnt++;
    go_to_wait(4'd4, 32'hFFFF_0000, 32'h0000_FFFF);
    drive_beat(8'hC0, 1'b0);
    drive_beat(8'hC1, 1'b0);
    drive_beat(8'hC2, 1'b0);
    drive_beat(8'hC3, 1'b0);
    total_cnt++; if (done !== 1'b1 || result !== 32'hC3C2_C1C0 || error !== 1'b0) $display("FAIL rst_mid_after got done=%b result=%h error=%b exp 1/c3c2c1c0/0", done, result, error); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_timeout();
    test_beat_wins_tie();
    test_fabric_error();
    test_ignored();
    test_back_to_back();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached before summary");
    $fatal(1);
  end

endmodule
